// File: rtl/stdcell_chk_pkg.sv
// Shared types and helpers for the exhaustive standard-cell checker.
package stdcell_chk_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StCheck,
        StDone
    } state_e;

    localparam int unsigned MAX_NIN     = 8;
    localparam int unsigned MAX_NOUT    = 4;
    localparam int unsigned MAX_TRUTH_W = (2 ** MAX_NIN) * MAX_NOUT;

    function automatic int unsigned nvec_of(input int unsigned nin);
        return 32'd1 << nin;
    endfunction

    // Expected outputs for one input vector: the nout-wide slice at vec*nout.
    function automatic logic [MAX_NOUT-1:0] expected(input logic [MAX_TRUTH_W-1:0] truth,
                                                     input int unsigned nout,
                                                     input int unsigned vec);
        logic [MAX_NOUT-1:0] mask;
        mask = MAX_NOUT'((32'd1 << nout) - 32'd1);
        return MAX_NOUT'(truth >> (vec * nout)) & mask;
    endfunction

endpackage

// File: rtl/stdcell_chk_settle_cnt.sv
// Settle-time down-counter: load SETTLE-1, count down, tc when it reaches zero.
module stdcell_chk_settle_cnt #(
    parameter int unsigned SETTLE = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic en,
    output logic tc
);

    localparam int unsigned CW = $clog2(SETTLE + 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= CW'(SETTLE - 1);
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/stdcell_exhaustive_checker.sv
// Exhaustive truth-table checker: sweeps all input vectors into a combinational cell
// and records mismatches against the TRUTH parameter.
module stdcell_exhaustive_checker
    import stdcell_chk_pkg::*;
#(
    parameter int unsigned                  NIN          = 3,
    parameter int unsigned                  NOUT         = 1,
    parameter logic [(2**NIN)*NOUT-1:0]     TRUTH        = 8'h15,
    parameter int unsigned                  SETTLE       = 1,
    parameter bit                           STOP_ON_FAIL = 1'b0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    output logic [NIN-1:0]  dut_in,
    input  logic [NOUT-1:0] dut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [NIN:0]    err_count,
    output logic [NIN-1:0]  fail_vec,
    output logic [NOUT-1:0] fail_act,
    output logic [NOUT-1:0] fail_exp
);

    localparam int unsigned NVEC = nvec_of(NIN);
    localparam int unsigned ERRW = NIN + 1;

    state_e          state_q, state_d;
    logic [NIN-1:0]  vec_q;
    logic [ERRW-1:0] err_q;
    logic [NIN-1:0]  fail_vec_q;
    logic [NOUT-1:0] fail_act_q;
    logic [NOUT-1:0] fail_exp_q;

    logic [NOUT-1:0] exp_out;
    logic            mismatch;
    logic            last_vec;
    logic            start_ok;
    logic            cnt_load;
    logic            cnt_tc;

    assign exp_out  = NOUT'(expected(MAX_TRUTH_W'(TRUTH), NOUT, 32'(vec_q)));
    // X/Z on the cell outputs must read as a failure, hence case-inequality.
    assign mismatch = (dut_out !== exp_out);
    assign last_vec = &vec_q;
    assign start_ok = start && ((state_q == StIdle) || (state_q == StDone));
    assign cnt_load = start_ok || ((state_q == StCheck) && (state_d == StSettle));

    stdcell_chk_settle_cnt #(
        .SETTLE (SETTLE)
    ) u_settle_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (cnt_load),
        .en      (state_q == StSettle),
        .tc      (cnt_tc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start) state_d = StSettle;
            StSettle: if (cnt_tc) state_d = StCheck;
            StCheck: begin
                if (last_vec || (STOP_ON_FAIL && mismatch)) state_d = StDone;
                else                                        state_d = StSettle;
            end
            StDone:   if (start) state_d = StSettle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vec_q      <= '0;
            err_q      <= '0;
            fail_vec_q <= '0;
            fail_act_q <= '0;
            fail_exp_q <= '0;
        end else if (start_ok) begin
            vec_q      <= '0;
            err_q      <= '0;
            fail_vec_q <= '0;
            fail_act_q <= '0;
            fail_exp_q <= '0;
        end else if (state_q == StCheck) begin
            if (mismatch) begin
                if (err_q != ERRW'(NVEC)) err_q <= err_q + 1'b1;
                if (err_q == '0) begin
                    fail_vec_q <= vec_q;
                    fail_act_q <= dut_out;
                    fail_exp_q <= exp_out;
                end
            end
            if (state_d == StSettle) vec_q <= vec_q + 1'b1;
        end
    end

    always_comb begin
        busy = (state_q == StSettle) || (state_q == StCheck);
        done = (state_q == StDone);
        pass = done && (err_q == '0);
    end

    assign dut_in    = vec_q;
    assign err_count = err_q;
    assign fail_vec  = fail_vec_q;
    assign fail_act  = fail_act_q;
    assign fail_exp  = fail_exp_q;

endmodule

// File: tb/tb_stdcell_exhaustive_checker.sv
// Directed bench: AOI21 cell models (good, stuck-at-1, two-cycle delayed) against four checkers.
module tb_stdcell_exhaustive_checker;

    logic clk;
    logic reset_n;
    logic start_main, start_aux;
    logic fault;
    int   n_asserts = 0;
    int   n_fail    = 0;

    function automatic logic aoi(input logic [2:0] v);
        return ~((v[2] & v[1]) | v[0]);
    endfunction

    // Main checker: default config, cell is good or stuck-at-1 under control of 'fault'.
    logic [2:0] m_in, m_fvec;
    logic       m_out, m_busy, m_done, m_pass, m_fact, m_fexp;
    logic [3:0] m_err;
    assign m_out = fault ? 1'b1 : aoi(m_in);

    stdcell_exhaustive_checker #(
        .NIN(3), .NOUT(1), .TRUTH(8'h15), .SETTLE(1), .STOP_ON_FAIL(1'b0)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start_main), .dut_in(m_in), .dut_out(m_out),
        .busy(m_busy), .done(m_done), .pass(m_pass), .err_count(m_err),
        .fail_vec(m_fvec), .fail_act(m_fact), .fail_exp(m_fexp)
    );

    // Stop-on-fail checker, cell stuck at 1.
    logic [2:0] s_in, s_fvec;
    logic       s_busy, s_done, s_pass, s_fact, s_fexp;
    logic [3:0] s_err;

    stdcell_exhaustive_checker #(
        .NIN(3), .NOUT(1), .TRUTH(8'h15), .SETTLE(1), .STOP_ON_FAIL(1'b1)
    ) u_stop (
        .clk(clk), .reset_n(reset_n), .start(start_aux), .dut_in(s_in), .dut_out(1'b1),
        .busy(s_busy), .done(s_done), .pass(s_pass), .err_count(s_err),
        .fail_vec(s_fvec), .fail_act(s_fact), .fail_exp(s_fexp)
    );

    // Slow cell (2-cycle output delay) checked with SETTLE=3 and SETTLE=1.
    logic [2:0] a_in, a_fvec, b_in, b_fvec;
    logic       a_busy, a_done, a_pass, a_fact, a_fexp;
    logic       b_busy, b_done, b_pass, b_fact, b_fexp;
    logic [3:0] a_err, b_err;
    logic       a_d1, a_d2, b_d1, b_d2;

    always @(posedge clk) begin
        a_d1 <= aoi(a_in);
        a_d2 <= a_d1;
        b_d1 <= aoi(b_in);
        b_d2 <= b_d1;
    end

    stdcell_exhaustive_checker #(
        .NIN(3), .NOUT(1), .TRUTH(8'h15), .SETTLE(3), .STOP_ON_FAIL(1'b0)
    ) u_slow3 (
        .clk(clk), .reset_n(reset_n), .start(start_aux), .dut_in(a_in), .dut_out(a_d2),
        .busy(a_busy), .done(a_done), .pass(a_pass), .err_count(a_err),
        .fail_vec(a_fvec), .fail_act(a_fact), .fail_exp(a_fexp)
    );

    stdcell_exhaustive_checker #(
        .NIN(3), .NOUT(1), .TRUTH(8'h15), .SETTLE(1), .STOP_ON_FAIL(1'b0)
    ) u_slow1 (
        .clk(clk), .reset_n(reset_n), .start(start_aux), .dut_in(b_in), .dut_out(b_d2),
        .busy(b_busy), .done(b_done), .pass(b_pass), .err_count(b_err),
        .fail_vec(b_fvec), .fail_act(b_fact), .fail_exp(b_fexp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_main();
        start_main = 1'b1;
        @(negedge clk);
        start_main = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b0;
        start_main = 1'b0;
        start_aux  = 1'b0;
        fault      = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state of every instance: all outputs zero.
        chk("rst_main", 32'({m_in, m_busy, m_done, m_pass, m_err, m_fvec, m_fact, m_fexp}), 0);
        chk("rst_stop", 32'({s_in, s_busy, s_done, s_pass, s_err, s_fvec, s_fact, s_fexp}), 0);
        chk("rst_slow3", 32'({a_in, a_busy, a_done, a_pass, a_err, a_fvec, a_fact, a_fexp}), 0);
        chk("rst_slow1", 32'({b_in, b_busy, b_done, b_pass, b_err, b_fvec, b_fact, b_fexp}), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Good cell: 16 busy cycles, dut_in steps every 2 cycles, then pass.
        pulse_main();
        for (int k = 0; k < 16; k++) begin
            chk("good_busy", 32'(m_busy), 1);
            chk("good_dut_in", 32'(m_in), 32'(k >> 1));
            @(negedge clk);
        end
        chk("good_done", 32'(m_done), 1);
        chk("good_busy_end", 32'(m_busy), 0);
        chk("good_pass", 32'(m_pass), 1);
        chk("good_err", 32'(m_err), 0);

        // Stuck-at-1: vectors 1,3,5,6,7 fail; first is 1.
        fault = 1'b1;
        pulse_main();
        repeat (16) @(negedge clk);
        chk("stuck_done", 32'(m_done), 1);
        chk("stuck_pass", 32'(m_pass), 0);
        chk("stuck_err", 32'(m_err), 5);
        chk("stuck_fvec", 32'(m_fvec), 1);
        chk("stuck_fact", 32'(m_fact), 1);
        chk("stuck_fexp", 32'(m_fexp), 0);

        // Aux sweeps: stop-on-fail, and the slow cell at SETTLE=3 and SETTLE=1.
        start_aux = 1'b1;
        @(negedge clk);
        start_aux = 1'b0;
        repeat (3) @(negedge clk);
        chk("stop_busy_c3", 32'(s_busy), 1);
        chk("stop_done_c3", 32'(s_done), 0);
        @(negedge clk);
        chk("stop_done_c4", 32'(s_done), 1);
        chk("stop_err", 32'(s_err), 1);
        chk("stop_fvec", 32'(s_fvec), 1);
        chk("stop_pass", 32'(s_pass), 0);
        repeat (12) @(negedge clk);
        chk("slow1_done", 32'(b_done), 1);
        chk("slow1_pass", 32'(b_pass), 0);
        chk("slow3_busy_c16", 32'(a_busy), 1);
        repeat (15) @(negedge clk);
        chk("slow3_busy_c31", 32'(a_busy), 1);
        chk("slow3_done_c31", 32'(a_done), 0);
        @(negedge clk);
        chk("slow3_done_c32", 32'(a_done), 1);
        chk("slow3_pass", 32'(a_pass), 1);
        chk("slow3_err", 32'(a_err), 0);

        // Reset during vector 4 of a faulty sweep, then a clean sweep.
        pulse_main();
        repeat (8) @(negedge clk);
        chk("abort_vec4", 32'(m_in), 4);
        chk("abort_err_pre", 32'(m_err), 2);
        reset_n = 1'b0;
        #1;
        chk("abort_zero", 32'({m_in, m_busy, m_done, m_pass, m_err, m_fvec, m_fact, m_fexp}), 0);
        @(negedge clk);
        reset_n = 1'b1;
        fault   = 1'b0;
        @(negedge clk);
        chk("abort_idle", 32'({m_busy, m_done, m_err}), 0);
        pulse_main();
        repeat (16) @(negedge clk);
        chk("rerun_done", 32'(m_done), 1);
        chk("rerun_pass", 32'(m_pass), 1);
        chk("rerun_err", 32'(m_err), 0);

        // start held high: ignored while busy, restarts from DONE with results cleared.
        fault      = 1'b1;
        start_main = 1'b1;
        @(negedge clk);
        chk("hold_busy0", 32'(m_busy), 1);
        chk("hold_in0", 32'(m_in), 0);
        repeat (5) @(negedge clk);
        chk("hold_in5", 32'(m_in), 2);
        repeat (11) @(negedge clk);
        chk("hold_done", 32'(m_done), 1);
        chk("hold_err", 32'(m_err), 5);
        @(negedge clk);
        chk("restart_busy", 32'(m_busy), 1);
        chk("restart_done", 32'(m_done), 0);
        chk("restart_in", 32'(m_in), 0);
        chk("restart_err", 32'(m_err), 0);
        chk("restart_fvec", 32'(m_fvec), 0);
        fault      = 1'b0;
        start_main = 1'b0;
        repeat (16) @(negedge clk);
        chk("restart_fin_done", 32'(m_done), 1);
        chk("restart_fin_pass", 32'(m_pass), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
